// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave exposing a 16-byte register file.
// All logic runs on BUS_CLK; SPI pins are oversampled.
module spi_slave_regs #(
  parameter logic [7:0] CHIP_ID         = 8'h02,
  parameter int         MIN_HALF_PERIOD = 4
) (
  input  logic         BUS_CLK,
  input  logic         BUS_RST,
  input  logic         SCLK,
  input  logic         SDI,
  input  logic         SEN,
  output logic         SDO,
  output logic         SDO_EN,
  output logic [127:0] REGS,
  output logic         WR_STROBE,
  output logic [3:0]   WR_ADDR,
  output logic [7:0]   TRANS_CNT
);

  if (MIN_HALF_PERIOD < 2) begin : g_hp_chk
    $error("MIN_HALF_PERIOD must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSTR,
    S_WR_DATA,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [1:0]       r_sclk_s;
  logic [1:0]       r_sdi_s;
  logic [1:0]       r_sen_s;
  logic             r_sclk_d;
  logic             r_sen_d;
  logic [1:0]       r_boot;
  logic             r_armed;
  logic [4:0]       r_bit_cnt;
  logic [14:0]      r_shift;
  logic             r_wr_ok;
  logic [3:0]       r_addr_lo;
  logic [7:0]       r_rd_byte;
  logic             r_sdo;
  logic             r_wr_strobe;
  logic [3:0]       r_wr_addr;
  logic [7:0]       r_trans_cnt;
  logic [15:1][7:0] r_regs;

  logic             w_sdi;
  logic             w_rise;
  logic             w_fall;
  logic             w_sen_rise;
  logic             w_sen_fall;
  logic [3:0]       w_addr_lo;
  logic             w_addr_hi0;
  logic [7:0]       w_rd_val;
  logic [7:0]       w_wr_data;
  logic [15:0][7:0] w_regs_all;
  logic             w_shift_en;
  logic             w_rd_load;
  logic             w_commit;
  logic             w_done;

  assign w_sdi      = r_sdi_s[1];
  assign w_rise     = r_sclk_s[1] & ~r_sclk_d;
  assign w_fall     = ~r_sclk_s[1] & r_sclk_d;
  assign w_sen_rise = r_sen_s[1] & ~r_sen_d;
  assign w_sen_fall = ~r_sen_s[1] & r_sen_d;
  // Address bits as seen on the 16th rise, SDI being A0.
  assign w_addr_lo  = {r_shift[2:0], w_sdi};
  assign w_addr_hi0 = (r_shift[11:3] == 9'd0);
  assign w_wr_data  = {r_shift[6:0], w_sdi};
  assign w_regs_all = {r_regs, CHIP_ID};
  assign w_rd_val   = w_addr_hi0 ? w_regs_all[w_addr_lo] : 8'h00;

  assign REGS      = w_regs_all;
  assign SDO_EN    = (r_state == S_RD_DATA);
  assign SDO       = r_sdo & SDO_EN;
  assign WR_STROBE = r_wr_strobe;
  assign WR_ADDR   = r_wr_addr;
  assign TRANS_CNT = r_trans_cnt;

  // Synchronize pins, keep delayed copies for edge detection.
  // Arming waits until SEN is seen low after reset.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_sclk_s <= '0;
      r_sdi_s  <= '0;
      r_sen_s  <= '0;
      r_sclk_d <= 1'b0;
      r_sen_d  <= 1'b0;
      r_boot   <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], SCLK};
      r_sdi_s  <= {r_sdi_s[0], SDI};
      r_sen_s  <= {r_sen_s[0], SEN};
      r_sclk_d <= r_sclk_s[1];
      r_sen_d  <= r_sen_s[1];
      r_boot   <= {r_boot[0], 1'b1};
      if (r_boot[1] && !r_sen_s[1]) r_armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_nx = r_state;
    w_shift_en = 1'b0;
    w_rd_load  = 1'b0;
    w_commit   = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_sen_rise && r_armed) w_state_nx = S_INSTR;
      end
      S_INSTR: begin
        if (w_sen_fall) begin
          w_state_nx = S_IDLE;
        end else if (w_rise) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 5'd15) begin
            w_rd_load  = r_shift[14];
            w_state_nx = r_shift[14] ? S_RD_DATA : S_WR_DATA;
          end
        end
      end
      S_WR_DATA, S_RD_DATA: begin
        if (w_rise && r_bit_cnt == 5'd23) begin
          w_commit   = (r_state == S_WR_DATA);
          w_state_nx = S_DONE;
          if (w_sen_fall) begin
            w_state_nx = S_IDLE;
            w_done     = 1'b1;
          end
        end else if (w_sen_fall) begin
          w_state_nx = S_IDLE;
        end else if (w_rise) begin
          w_shift_en = 1'b1;
        end
      end
      S_DONE: begin
        if (w_sen_fall) begin
          w_state_nx = S_IDLE;
          w_done     = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Frame datapath: shifter, bit counter, read serializer.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_wr_ok   <= 1'b0;
      r_addr_lo <= '0;
      r_rd_byte <= '0;
      r_sdo     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_sen_rise) r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 5'd1;
      if (w_shift_en) r_shift <= {r_shift[13:0], w_sdi};
      if (w_shift_en && r_bit_cnt == 5'd15) begin
        r_wr_ok   <= w_addr_hi0 && (w_addr_lo != 4'd0);
        r_addr_lo <= w_addr_lo;
      end
      if (w_rd_load) begin
        r_rd_byte <= w_rd_val;
        r_sdo     <= 1'b0;
      end else if (r_state == S_RD_DATA && w_fall) begin
        r_sdo     <= r_rd_byte[7];
        r_rd_byte <= {r_rd_byte[6:0], 1'b0};
      end
    end
  end

  // Register file writes, strobe and transaction counter.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_regs      <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_trans_cnt <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_commit && r_wr_ok) begin
        for (int i = 1; i < 16; i++) begin
          if (r_addr_lo == i[3:0]) r_regs[i] <= w_wr_data;
        end
        r_wr_strobe <= 1'b1;
        r_wr_addr   <= r_addr_lo;
      end
      if (w_done) r_trans_cnt <= r_trans_cnt + 8'd1;
    end
  end

endmodule
